// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_pkg
//  Description : Shared types and constants for the multi-cycle divide
//                sequencer (div_seq) and its single-step datapath
//                (div_seq_iter).
//                  - div_state_e : sequencer FSM state encoding
//                  - result-ready, start/stop and stall request levels
//  Revision    : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

   // Sequencer states. The encoding is shared with the rest of the core,
   // so it is fixed explicitly rather than left to the tool.
   typedef enum logic [1:0] {
      DIV_FREE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   // Result-ready levels for ready_o
   localparam logic c_DIV_RESULT_READY     = 1'b1;
   localparam logic c_DIV_RESULT_NOT_READY = 1'b0;

   // Divide request levels seen on start_i
   localparam logic c_DIV_START = 1'b1;
   localparam logic c_DIV_STOP  = 1'b0;

   // Stall request levels driven on stall_req_o
   localparam logic c_STOP    = 1'b1;
   localparam logic c_NO_STOP = 1'b0;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_iter
//  Description : One restoring shift-subtract step of an unsigned divide.
//                Purely combinational.
//                The {rem, quo} pair is shifted left by one. The shifted
//                remainder is then trial-subtracted by the divisor. If the
//                trial is non-negative it becomes the new remainder and the
//                new quotient LSB is set. Otherwise the shifted remainder is
//                kept and the LSB stays clear.
//  Ports       : i_rem  [WIDTH] partial remainder
//                i_quo  [WIDTH] partial quotient / remaining dividend bits
//                i_dvs  [WIDTH] divisor magnitude
//                o_rem  [WIDTH] next partial remainder
//                o_quo  [WIDTH] next partial quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq_iter
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dvs,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   // The shifted remainder needs WIDTH+1 bits. With an unsigned divisor
   // whose MSB is set, the remainder can reach 2^WIDTH after the shift.
   // A WIDTH+1 bit trial still classifies correctly. When the shifted value
   // is >= 2^WIDTH it always exceeds the divisor, and the difference fits
   // in WIDTH bits with the top bit clear.
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;
   logic           w_neg;

   assign w_shift = {i_rem, i_quo[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, i_dvs};
   assign w_neg   = w_trial[WIDTH];

   assign o_rem = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign o_quo = {i_quo[WIDTH-2:0], ~w_neg};

endmodule : div_seq_iter
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multi-cycle integer divide sequencer sitting beside EX.
//                Runs DIV / DIVU with an iterative restoring divider. There
//                is one quotient bit per cycle, followed by a single sign
//                fix-up cycle. While the divide is in flight it holds the
//                pipeline through stall_req_o. It returns {remainder,
//                quotient} for the HI/LO write path as a one-cycle pulse.
//                A flush (annul_i) abandons the in-flight divide.
//
//  Optional    : `DIV_EARLY_OUT_EN
//                When defined, operands with |dividend| < |divisor| finish
//                through the short BYZERO path. The result is quotient 0 and
//                remainder = original dividend. When undefined, such
//                operands take the full iterative path with identical
//                results.
//
//  Ports       : clk          clock, rising edge
//                rst          synchronous active-high reset
//                signed_div_i 1 = DIV (signed), 0 = DIVU
//                opdata1_i    dividend
//                opdata2_i    divisor
//                start_i      divide request, level, held while stalled
//                annul_i      cancel the in-flight divide
//                result_o     {remainder, quotient}, valid with ready_o
//                ready_o      one-cycle result-valid pulse
//                stall_req_o  stall request to the pipeline controller
//
//  Latency     : start accepted in cycle N
//                  normal        -> ready_o in cycle N+WIDTH+2
//                  divide-by-0   -> ready_o in cycle N+2
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               stall_req_o
);

   // ------------------------------------------------------------------
   // State and working registers
   // ------------------------------------------------------------------
   div_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_rem;      // partial remainder
   logic [WIDTH-1:0]   r_quo;      // partial quotient / dividend bits
   logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
   logic               r_neg_dvd;  // signed divide with negative dividend
   logic               r_neg_dvs;  // signed divide with negative divisor
   logic [2*WIDTH-1:0] r_result;
   logic               r_ready;

   // ------------------------------------------------------------------
   // Acceptance-time operand decode (only used in FREE)
   // ------------------------------------------------------------------
   logic             w_req;
   logic             w_dvs_zero;
   logic             w_neg1;
   logic             w_neg2;
   logic [WIDTH-1:0] w_mag1;
   logic [WIDTH-1:0] w_mag2;
   logic             w_early;

   assign w_req      = (start_i == c_DIV_START) && !annul_i;
   assign w_dvs_zero = (opdata2_i == '0);
   assign w_neg1     = signed_div_i && opdata1_i[WIDTH-1];
   assign w_neg2     = signed_div_i && opdata2_i[WIDTH-1];
   assign w_mag1     = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
   assign w_mag2     = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

`ifdef DIV_EARLY_OUT_EN
   // The divisor-zero case has priority in the FSM, so there is no need
   // to qualify this with a nonzero divisor here.
   assign w_early = (w_mag1 < w_mag2);
`else
   assign w_early = 1'b0;
`endif

   // ------------------------------------------------------------------
   // One restoring step per ON cycle
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;

   div_seq_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_dvs (r_dvs),
      .o_rem (w_rem_nxt),
      .o_quo (w_quo_nxt)
   );

   // ------------------------------------------------------------------
   // Sign fix-up applied once, after the last iteration
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_quo_fix;
   logic [WIDTH-1:0] w_rem_fix;

   assign w_quo_fix = (r_neg_dvd ^ r_neg_dvs) ? (~r_quo + 1'b1) : r_quo;
   assign w_rem_fix = r_neg_dvd               ? (~r_rem + 1'b1) : r_rem;

   // ------------------------------------------------------------------
   // Sequencer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= DIV_FREE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_neg_dvd <= 1'b0;
         r_neg_dvs <= 1'b0;
         r_result  <= '0;
         r_ready   <= c_DIV_RESULT_NOT_READY;
      end else begin
         case (r_state)
            DIV_FREE: begin
               r_result <= '0;
               r_ready  <= c_DIV_RESULT_NOT_READY;
               if (w_req) begin
                  if (w_dvs_zero) begin
                     // BYZERO reports {r_rem, r_quo}, so clear both here
                     r_state <= DIV_BYZERO;
                     r_rem   <= '0;
                     r_quo   <= '0;
                  end else if (w_early) begin
                     // Short path: remainder is the untouched dividend,
                     // so its sign is preserved automatically.
                     r_state <= DIV_BYZERO;
                     r_rem   <= opdata1_i;
                     r_quo   <= '0;
                  end else begin
                     r_state   <= DIV_ON;
                     r_rem     <= '0;
                     r_quo     <= w_mag1;
                     r_dvs     <= w_mag2;
                     r_neg_dvd <= w_neg1;
                     r_neg_dvs <= w_neg2;
                     r_cnt     <= '0;
                  end
               end
            end

            DIV_BYZERO: begin
               if (annul_i) begin
                  r_state <= DIV_FREE;
               end else begin
                  r_state  <= DIV_END;
                  r_result <= {r_rem, r_quo};
                  r_ready  <= c_DIV_RESULT_READY;
               end
            end

            DIV_ON: begin
               if (annul_i) begin
                  r_state <= DIV_FREE;
               end else if (r_cnt == CNT_W'(WIDTH)) begin
                  r_state  <= DIV_END;
                  r_result <= {w_rem_fix, w_quo_fix};
                  r_ready  <= c_DIV_RESULT_READY;
               end else begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            DIV_END: begin
               // Result is visible for exactly this cycle; annul_i ignored
               r_state  <= DIV_FREE;
               r_result <= '0;
               r_ready  <= c_DIV_RESULT_NOT_READY;
            end

            default: begin
               r_state <= DIV_FREE;
            end
         endcase
      end
   end

   // Combinational so that the accept cycle itself already stalls. It
   // drops in END, the cycle in which EX captures the result.
   assign stall_req_o = (w_req && (r_state != DIV_END)) ? c_STOP : c_NO_STOP;

   assign result_o = r_result;
   assign ready_o  = r_ready;

endmodule : div_seq
`default_nettype wire
